// File: rtl/mux_arbiter_pkg.sv
// ============================================================================
// Module      : mux_arbiter_pkg
// Description : Shared definitions for the round-robin bus-mux arbiter:
//               FSM state encoding and default sizing values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arbiter_pkg;

    // Arbiter FSM states; encodings are fixed so external views stay stable
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_WIDTH    = 16;
    localparam int DEF_MAX_HOLD = 8;

endpackage : mux_arbiter_pkg

`default_nettype wire

// File: rtl/mux_arbiter_bus_mux_n.sv
// ============================================================================
// Module      : bus_mux_n (with 2-input Mux cell)
// Description : NUM_REQ-to-1 WIDTH-bit bus mux built as a binary tree of
//               2-input Mux cells, followed by an AND gate that forces the
//               bus to zero while no grant is active.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Mux #(
    parameter int W = 16
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule : Mux

module bus_mux_n #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]         select,
    input  logic                     busy,
    input  logic [NUM_REQ*WIDTH-1:0] inData,
    output logic [WIDTH-1:0]         out
);

    // Level l holds NUM_REQ>>l candidates; select bit l-1 picks between pairs
    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        localparam int N = NUM_REQ >> l;
        logic [N*WIDTH-1:0] w_data;

        if (l == 0) begin : g_leaf
            assign w_data = inData;
        end else begin : g_node
            for (genvar j = 0; j < N; j++) begin : g_cell
                Mux #(.W(WIDTH)) u_mux (
                    .sel (select[l-1]),
                    .a   (g_lvl[l-1].w_data[(2*j)*WIDTH   +: WIDTH]),
                    .b   (g_lvl[l-1].w_data[(2*j+1)*WIDTH +: WIDTH]),
                    .y   (w_data[j*WIDTH +: WIDTH])
                );
            end
        end
    end

    // Bus is driven only while an owner holds the grant
    assign out = g_lvl[SEL_W].w_data & {WIDTH{busy}};

endmodule : bus_mux_n

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ============================================================================
// Module      : mux_arbiter
// Description : Round-robin arbiter sequencing a shared WIDTH-bit bus mux
//               between NUM_REQ requesters. Grant is held while the owner
//               keeps req high; handover happens on the same edge the owner
//               releases, starting the scan one past the current owner.
//               Optional macro MUX_ARB_TIMEOUT_EN adds a hold counter that
//               pre-empts an owner after MAX_HOLD grant cycles when another
//               requester is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SEL_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] inData,
    output logic [NUM_REQ-1:0]       grant,
    output logic [SEL_W-1:0]         select,
    output logic                     busy,
    output logic [WIDTH-1:0]         out
);

    // Elaboration-time sanity checks on the configuration
    if (SEL_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_badSize
        $error("mux_arbiter: NUM_REQ must be a power of two in 2..8 and SEL_W = log2(NUM_REQ)");
    end
    if (MAX_HOLD < 1) begin : g_badHold
        $error("mux_arbiter: MAX_HOLD must be at least 1");
    end

    arbState_t          r_state;
    logic [SEL_W-1:0]   r_last;
    logic [NUM_REQ-1:0] w_cand;
    logic [SEL_W-1:0]   w_idx;
    logic [SEL_W-1:0]   w_winner;
    logic               w_found;
    logic               w_preempt;
    logic               w_rearb;
    logic               w_take;

    // Candidates exclude the current owner; in IDLE grant is zero so all req count
    assign w_cand = req & ~grant;

    // Round-robin scan starting one past the last owner; index wraps naturally
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = r_last + SEL_W'(k);
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    logic [HOLD_W-1:0] r_hold;

    // The cycle now ending is grant cycle r_hold+1; pre-empt once it hits the limit
    assign w_preempt = (r_state == GRANT) && (r_hold >= HOLD_W'(MAX_HOLD - 1)) && (|w_cand);

    // Hold counter: cleared on every new grant, saturates at MAX_HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_take) begin
            r_hold <= '0;
        end else if (r_state == GRANT && r_hold != HOLD_W'(MAX_HOLD)) begin
            r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    // Arbitrate when idle, when the owner releases, or when it is pre-empted
    assign w_rearb = (r_state == IDLE) || !req[select] || w_preempt;
    assign w_take  = w_rearb && w_found;

    // Arbiter FSM with registered grant/select/busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= SEL_W'(NUM_REQ - 1);
            grant   <= '0;
            select  <= '0;
            busy    <= 1'b0;
        end else if (w_take) begin
            r_state <= GRANT;
            r_last  <= w_winner;
            grant   <= NUM_REQ'(1) << w_winner;
            select  <= w_winner;
            busy    <= 1'b1;
        end else if (r_state == GRANT && w_rearb) begin
            r_state <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
        end
    end

    bus_mux_n #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .SEL_W   (SEL_W)
    ) u_busMux (
        .select (select),
        .busy   (busy),
        .inData (inData),
        .out    (out)
    );

endmodule : mux_arbiter

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// ============================================================================
// Module      : tb_mux_arbiter
// Description : Self-checking bench for mux_arbiter: directed scenarios and
//               randomized requests compared against a behavioural
//               round-robin model. Honours MUX_ARB_TIMEOUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mux_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int WIDTH    = 16;
    localparam int SEL_W    = 2;
    localparam int MAX_HOLD = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] inData;
    logic [NUM_REQ-1:0]       grant;
    logic [SEL_W-1:0]         select;
    logic                     busy;
    logic [WIDTH-1:0]         out;

    mux_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .inData (inData),
        .grant  (grant),
        .select (select),
        .busy   (busy),
        .out    (out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: owner index (-1 = none), last owner, select, hold
    int mOwner;
    int mLast;
    int mSel;
    int mHold;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int scanFrom(input logic [NUM_REQ-1:0] v, input int start);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic grantTo(input int w);
        mOwner = w;
        mSel   = w;
        mLast  = w;
        mHold  = 0;
    endtask

    task automatic modelEdge(input logic rst, input logic [NUM_REQ-1:0] r);
        int                 w;
        logic [NUM_REQ-1:0] others;
        bit                 pre;
        if (rst) begin
            mOwner = -1;
            mLast  = NUM_REQ - 1;
            mSel   = 0;
            mHold  = 0;
            return;
        end
        if (mOwner < 0) begin
            w = scanFrom(r, mLast);
            if (w >= 0) grantTo(w);
        end else begin
            others         = r;
            others[mOwner] = 1'b0;
            pre            = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            pre = (mHold + 1 >= MAX_HOLD) && (others != '0);
`endif
            if (!r[mOwner] || pre) begin
                w = scanFrom(others, mOwner);
                if (w >= 0) grantTo(w);
                else mOwner = -1;
            end else if (mHold < MAX_HOLD) begin
                mHold++;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, check just after the edge
    task automatic step(input logic rst, input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] expG;
        logic [WIDTH-1:0]   expO;
        reset  = rst;
        req    = r;
        inData = {$urandom, $urandom};
        modelEdge(rst, r);
        @(posedge clk);
        #1;
        expG = (mOwner >= 0) ? NUM_REQ'(1 << mOwner) : '0;
        expO = (mOwner >= 0) ? inData[mSel*WIDTH +: WIDTH] : '0;
        checkVal("grant",  64'(grant),  64'(expG));
        checkVal("busy",   64'(busy),   64'(mOwner >= 0));
        checkVal("select", 64'(select), 64'(mSel));
        checkVal("out",    64'(out),    64'(expO));
    endtask

    initial begin
        logic [NUM_REQ-1:0] r;
        logic               rst;

        // Reset, then idle bus
        step(1'b1, '0);
        step(1'b1, '0);
        repeat (5) step(1'b0, '0);

        // All requesting; each owner releases after two grant cycles
        for (int i = 0; i < 14; i++) begin
            r = '1;
            if (mOwner >= 0 && mHold >= 1) r[mOwner] = 1'b0;
            step(1'b0, r);
        end

        // Owner 2 releases with 0,1,3 pending -> 3, then wrap to 0
        step(1'b1, '0);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        checkVal("own2", 64'(grant), 64'(4'b0100));
        step(1'b0, 4'b1011);
        checkVal("next3", 64'(grant), 64'(4'b1000));
        step(1'b0, 4'b0011);
        checkVal("wrap0", 64'(grant), 64'(4'b0001));

        // Lone requester 1: one-cycle latency, release returns bus to idle
        step(1'b1, '0);
        repeat (3) step(1'b0, 4'b0010);
        checkVal("lone1", 64'(grant), 64'(4'b0010));
        step(1'b0, '0);
        checkVal("lone1_idle", 64'({busy, out}), 64'(0));

        // Reset while requester 1 owns the bus; requester 0 wins afterwards
        step(1'b0, 4'b0010);
        step(1'b1, 4'b1111);
        checkVal("rst_mid", 64'(grant), 64'(0));
        step(1'b0, 4'b1111);
        checkVal("after_rst", 64'(grant), 64'(4'b0001));

        // Long hold by requester 0 with 2 joining later, then 0 alone
        step(1'b1, '0);
        for (int i = 0; i < 14; i++) step(1'b0, (i >= 3) ? 4'b0101 : 4'b0001);
        step(1'b1, '0);
        for (int i = 0; i < 14; i++) step(1'b0, 4'b0001);
        checkVal("solo_hold", 64'(grant), 64'(4'b0001));

        // Randomized traffic; owners mostly keep requesting
        for (int i = 0; i < 400; i++) begin
            r = NUM_REQ'($urandom);
            if (mOwner >= 0 && ($urandom % 4) != 0) r[mOwner] = 1'b1;
            rst = (($urandom % 50) == 0);
            step(rst, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule : tb_mux_arbiter

`default_nettype wire
